// File: rtl/alt_vipcts131_ctrl_pkg.sv
// Shared types and constants for the VIP control-update sequencer.
// Slave map: 0 control (bit0 go), 1 status (bit0 stopped), 2 irq, 3+i register i.
package alt_vipcts131_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StRdCtrl,
        StWrStop,
        StPoll,
        StWrReg,
        StRbRd,
        StWrGo
    } cts_state_e;

    localparam int unsigned CTRL_ADDR   = 0;
    localparam int unsigned STATUS_ADDR = 1;
    localparam int unsigned IRQ_ADDR    = 2;
    localparam int unsigned REG_BASE    = 3;
    localparam int unsigned GO_BIT      = 0;
    localparam int unsigned STOPPED_BIT = 0;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alt_vipcts131_avmm_master_port.sv
// Avalon-MM master port: drives the request held by the sequencer until accepted and
// flags the cycle in which read data is valid (exactly one cycle after acceptance).
module alt_vipcts131_avmm_master_port #(
    parameter int unsigned AV_ADDRESS_WIDTH = 5,
    parameter int unsigned AV_DATA_WIDTH    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AV_ADDRESS_WIDTH-1:0] addr_i,
    input  logic [AV_DATA_WIDTH-1:0]    wdata_i,
    output logic                        ack_o,
    output logic                        rdata_valid_o,
    output logic [AV_DATA_WIDTH-1:0]    rdata_o,
    output logic [AV_ADDRESS_WIDTH-1:0] av_address_o,
    output logic                        av_read_o,
    output logic                        av_write_o,
    output logic [AV_DATA_WIDTH-1:0]    av_writedata_o,
    input  logic [AV_DATA_WIDTH-1:0]    av_readdata_i,
    input  logic                        av_waitrequest_i
);

    logic rdata_valid_q;

    assign av_read_o      = req_i & ~we_i;
    assign av_write_o     = req_i & we_i;
    assign av_address_o   = req_i ? addr_i : '0;
    assign av_writedata_o = (req_i & we_i) ? wdata_i : '0;
    assign ack_o          = req_i & ~av_waitrequest_i;
    assign rdata_valid_o  = rdata_valid_q;
    assign rdata_o        = av_readdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= av_read_o & ~av_waitrequest_i;
        end
    end

endmodule

// File: rtl/alt_vipcts131_ctrl_update_sequencer.sv
// Applies a staged batch of register writes to a VIP control slave at the next safe point.
// Optional CTS_READBACK_VERIFY_EN: read back each register write and flag mismatches.
module alt_vipcts131_ctrl_update_sequencer
    import alt_vipcts131_ctrl_pkg::*;
#(
    parameter int unsigned AV_ADDRESS_WIDTH = 5,
    parameter int unsigned AV_DATA_WIDTH    = 16,
    parameter int unsigned NO_ENTRIES       = 4,
    parameter int unsigned POLL_LIMIT       = 255,
    localparam int unsigned IDX_W           = idx_w(NO_ENTRIES)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_wr_i,
    input  logic [IDX_W-1:0]            cfg_index_i,
    input  logic [AV_ADDRESS_WIDTH-1:0] cfg_reg_i,
    input  logic [AV_DATA_WIDTH-1:0]    cfg_data_i,
    input  logic                        cfg_commit_i,
    input  logic [IDX_W:0]              cfg_count_i,
    input  logic                        sync_i,
    output logic [AV_ADDRESS_WIDTH-1:0] av_address_o,
    output logic                        av_read_o,
    output logic                        av_write_o,
    output logic [AV_DATA_WIDTH-1:0]    av_writedata_o,
    input  logic [AV_DATA_WIDTH-1:0]    av_readdata_i,
    input  logic                        av_waitrequest_i,
    output logic                        armed_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        timeout_err_o
`ifdef CTS_READBACK_VERIFY_EN
    ,
    output logic                        readback_err_o
`endif
);

    localparam int unsigned CW = IDX_W + 1;
    localparam logic [AV_DATA_WIDTH-1:0] GoMask = AV_DATA_WIDTH'(1) << GO_BIT;
    localparam logic [CW-1:0] MaxCount = CW'(NO_ENTRIES);
    localparam logic [AV_ADDRESS_WIDTH-1:0] CtrlAddr   = AV_ADDRESS_WIDTH'(CTRL_ADDR);
    localparam logic [AV_ADDRESS_WIDTH-1:0] StatusAddr = AV_ADDRESS_WIDTH'(STATUS_ADDR);
    localparam logic [AV_ADDRESS_WIDTH-1:0] RegBase    = AV_ADDRESS_WIDTH'(REG_BASE);

    cts_state_e                  state_q;
    logic                        req_q, we_q;
    logic [AV_ADDRESS_WIDTH-1:0] addr_q;
    logic [AV_DATA_WIDTH-1:0]    wdata_q;
    logic [AV_ADDRESS_WIDTH-1:0] ent_reg_q  [NO_ENTRIES];
    logic [AV_DATA_WIDTH-1:0]    ent_data_q [NO_ENTRIES];
    logic [AV_DATA_WIDTH-1:0]    ctrl_saved_q;
    logic [CW-1:0]               count_q, k_q;
    logic [15:0]                 poll_cnt_q;
    logic                        done_q, timeout_q;
`ifdef CTS_READBACK_VERIFY_EN
    logic                        rb_err_q;
`endif

    logic                     ack, rd_valid;
    logic [AV_DATA_WIDTH-1:0] rdata;
    logic [CW-1:0]            commit_count, k_next;
    logic                     last_entry, stage_wr, poll_exhausted;

    assign commit_count   = (cfg_count_i > MaxCount) ? MaxCount : cfg_count_i;
    assign k_next         = k_q + CW'(1);
    assign last_entry     = (k_next == count_q);
    assign stage_wr       = cfg_wr_i && (state_q == StIdle || state_q == StArmed)
                            && ({1'b0, cfg_index_i} < MaxCount);
    assign poll_exhausted = ({1'b0, poll_cnt_q} + 17'd1) == 17'(POLL_LIMIT);

    assign armed_o       = (state_q == StArmed);
    assign busy_o        = (state_q != StIdle) && (state_q != StArmed);
    assign done_o        = done_q;
    assign timeout_err_o = timeout_q;
`ifdef CTS_READBACK_VERIFY_EN
    assign readback_err_o = rb_err_q;
`endif

    alt_vipcts131_avmm_master_port #(
        .AV_ADDRESS_WIDTH(AV_ADDRESS_WIDTH),
        .AV_DATA_WIDTH   (AV_DATA_WIDTH)
    ) u_port (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_i           (req_q),
        .we_i            (we_q),
        .addr_i          (addr_q),
        .wdata_i         (wdata_q),
        .ack_o           (ack),
        .rdata_valid_o   (rd_valid),
        .rdata_o         (rdata),
        .av_address_o    (av_address_o),
        .av_read_o       (av_read_o),
        .av_write_o      (av_write_o),
        .av_writedata_o  (av_writedata_o),
        .av_readdata_i   (av_readdata_i),
        .av_waitrequest_i(av_waitrequest_i)
    );

    // Every transition that starts a bus access loads req/we/addr/wdata at the same edge,
    // so the request appears on the bus in the first cycle of the new state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ctrl_saved_q <= '0;
            count_q      <= '0;
            k_q          <= '0;
            poll_cnt_q   <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef CTS_READBACK_VERIFY_EN
            rb_err_q     <= 1'b0;
`endif
            for (int i = 0; i < NO_ENTRIES; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (stage_wr) begin
                ent_reg_q[cfg_index_i]  <= cfg_reg_i;
                ent_data_q[cfg_index_i] <= cfg_data_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (cfg_commit_i) begin
                        count_q   <= commit_count;
                        timeout_q <= 1'b0;
`ifdef CTS_READBACK_VERIFY_EN
                        rb_err_q  <= 1'b0;
`endif
                        state_q   <= StArmed;
                    end
                end
                StArmed: begin
                    if (cfg_commit_i) begin
                        count_q   <= commit_count;
                        timeout_q <= 1'b0;
`ifdef CTS_READBACK_VERIFY_EN
                        rb_err_q  <= 1'b0;
`endif
                    end
                    if (sync_i) begin
                        state_q <= StRdCtrl;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= CtrlAddr;
                    end
                end
                StRdCtrl: begin
                    if (req_q) begin
                        if (ack) req_q <= 1'b0;
                    end else if (rd_valid) begin
                        ctrl_saved_q <= rdata;
                        state_q      <= StWrStop;
                        req_q        <= 1'b1;
                        we_q         <= 1'b1;
                        addr_q       <= CtrlAddr;
                        wdata_q      <= rdata & ~GoMask;
                    end
                end
                StWrStop: begin
                    if (ack) begin
                        state_q    <= StPoll;
                        we_q       <= 1'b0;
                        addr_q     <= StatusAddr;
                        poll_cnt_q <= '0;
                    end
                end
                StPoll: begin
                    if (req_q) begin
                        if (ack) req_q <= 1'b0;
                    end else if (rd_valid) begin
                        req_q <= 1'b1;
                        if (rdata[STOPPED_BIT] && count_q != '0) begin
                            state_q <= StWrReg;
                            k_q     <= '0;
                            we_q    <= 1'b1;
                            addr_q  <= ent_reg_q[0] + RegBase;
                            wdata_q <= ent_data_q[0];
                        end else if (rdata[STOPPED_BIT] || poll_exhausted) begin
                            // Timeout still restores go so the core is never left stopped.
                            timeout_q <= timeout_q | ~rdata[STOPPED_BIT];
                            state_q   <= StWrGo;
                            we_q      <= 1'b1;
                            addr_q    <= CtrlAddr;
                            wdata_q   <= ctrl_saved_q | GoMask;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 16'd1;
                        end
                    end
                end
                StWrReg: begin
                    if (ack) begin
`ifdef CTS_READBACK_VERIFY_EN
                        state_q <= StRbRd;
                        we_q    <= 1'b0;
`else
                        if (last_entry) begin
                            state_q <= StWrGo;
                            addr_q  <= CtrlAddr;
                            wdata_q <= ctrl_saved_q | GoMask;
                        end else begin
                            k_q     <= k_next;
                            addr_q  <= ent_reg_q[k_next[IDX_W-1:0]] + RegBase;
                            wdata_q <= ent_data_q[k_next[IDX_W-1:0]];
                        end
`endif
                    end
                end
`ifdef CTS_READBACK_VERIFY_EN
                StRbRd: begin
                    if (req_q) begin
                        if (ack) req_q <= 1'b0;
                    end else if (rd_valid) begin
                        if (rdata != wdata_q) rb_err_q <= 1'b1;
                        req_q <= 1'b1;
                        we_q  <= 1'b1;
                        if (last_entry) begin
                            state_q <= StWrGo;
                            addr_q  <= CtrlAddr;
                            wdata_q <= ctrl_saved_q | GoMask;
                        end else begin
                            state_q <= StWrReg;
                            k_q     <= k_next;
                            addr_q  <= ent_reg_q[k_next[IDX_W-1:0]] + RegBase;
                            wdata_q <= ent_data_q[k_next[IDX_W-1:0]];
                        end
                    end
                end
`endif
                StWrGo: begin
                    if (ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alt_vipcts131_ctrl_update_sequencer.sv
// Self-checking bench: behavioural VIP slave plus a transaction-list reference model.
`timescale 1ns/1ps
module tb_alt_vipcts131_ctrl_update_sequencer;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned NE = 4;
    localparam int unsigned PL = 4;
    localparam int unsigned IW = 2;

    typedef logic [AW+DW:0] txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_wr = 1'b0, cfg_commit = 1'b0, sync = 1'b0;
    logic [IW-1:0] cfg_index = '0;
    logic [AW-1:0] cfg_reg = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [IW:0]   cfg_count = '0;
    logic [AW-1:0] av_address;
    logic          av_read, av_write;
    logic [DW-1:0] av_writedata;
    logic [DW-1:0] av_readdata = '0;
    logic          av_waitrequest = 1'b0;
    logic          armed, busy, done, timeout_err;
`ifdef CTS_READBACK_VERIFY_EN
    logic          readback_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alt_vipcts131_ctrl_update_sequencer #(
        .AV_ADDRESS_WIDTH(AW),
        .AV_DATA_WIDTH   (DW),
        .NO_ENTRIES      (NE),
        .POLL_LIMIT      (PL)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_wr_i        (cfg_wr),
        .cfg_index_i     (cfg_index),
        .cfg_reg_i       (cfg_reg),
        .cfg_data_i      (cfg_data),
        .cfg_commit_i    (cfg_commit),
        .cfg_count_i     (cfg_count),
        .sync_i          (sync),
        .av_address_o    (av_address),
        .av_read_o       (av_read),
        .av_write_o      (av_write),
        .av_writedata_o  (av_writedata),
        .av_readdata_i   (av_readdata),
        .av_waitrequest_i(av_waitrequest),
        .armed_o         (armed),
        .busy_o          (busy),
        .done_o          (done),
        .timeout_err_o   (timeout_err)
`ifdef CTS_READBACK_VERIFY_EN
        ,
        .readback_err_o  (readback_err)
`endif
    );

    // Behavioural slave, evaluated mid-cycle while DUT outputs are stable.
    logic [DW-1:0] mem [32];
    bit            slave_stopped = 1'b1;
    bit            stall_en = 1'b0;
    txn_t          log_q [$];
    txn_t          exp_q [$];
    int            stab_err = 0;
    bit            p_stall = 1'b0;
    logic          p_rd, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_stall        = 1'b0;
            av_waitrequest = 1'b0;
        end else begin
            if (av_read && av_write) stab_err++;
            if (p_stall && (av_read !== p_rd || av_write !== p_wr || av_address !== p_addr ||
                            (p_wr && av_writedata !== p_wd))) stab_err++;
            av_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
            if ((av_read || av_write) && !av_waitrequest) begin
                if (av_write) begin
                    log_q.push_back({1'b1, av_address, av_writedata});
                    if (av_address != 5'd1) mem[av_address] = av_writedata;
                end else begin
                    log_q.push_back({1'b0, av_address, 16'h0000});
                    av_readdata = (av_address == 5'd1) ? {15'd0, slave_stopped}
                                                       : mem[av_address];
                end
            end
            p_stall = (av_read || av_write) && av_waitrequest;
            p_rd    = av_read;
            p_wr    = av_write;
            p_addr  = av_address;
            p_wd    = av_writedata;
        end
    end

    // Reference model of the staging buffer and committed batch size.
    logic [AW-1:0] m_reg  [NE];
    logic [DW-1:0] m_data [NE];
    int            m_count = 0;

    function automatic txn_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {w, a, d};
    endfunction

    task automatic build_expected(input logic [DW-1:0] ctrl, input bit stopped);
        logic [AW-1:0] a;
        exp_q.delete();
        exp_q.push_back(mk(1'b0, 5'd0, 16'h0));
        exp_q.push_back(mk(1'b1, 5'd0, ctrl & 16'hFFFE));
        if (stopped) begin
            exp_q.push_back(mk(1'b0, 5'd1, 16'h0));
            for (int k = 0; k < m_count; k++) begin
                a = m_reg[k] + 5'd3;
                exp_q.push_back(mk(1'b1, a, m_data[k]));
`ifdef CTS_READBACK_VERIFY_EN
                exp_q.push_back(mk(1'b0, a, 16'h0));
`endif
            end
        end else begin
            for (int i = 0; i < PL; i++) exp_q.push_back(mk(1'b0, 5'd1, 16'h0));
        end
        exp_q.push_back(mk(1'b1, 5'd0, ctrl | 16'h0001));
    endtask

    function automatic int expected_latency();
`ifdef CTS_READBACK_VERIFY_EN
        return m_count * 3 + 7;
`else
        return m_count + 7;
`endif
    endfunction

    function automatic int first_diff();
        if (log_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic stage(input int idx, input logic [AW-1:0] r, input logic [DW-1:0] d);
        cfg_wr = 1'b1; cfg_index = IW'(idx); cfg_reg = r; cfg_data = d;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        m_reg[idx] = r;
        m_data[idx] = d;
    endtask

    task automatic commit(input int cnt);
        cfg_commit = 1'b1; cfg_count = (IW+1)'(cnt);
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        m_count = (cnt > NE) ? NE : cnt;
    endtask

    // n = edges from the sync-sampling edge to done; -1 if the bound expires.
    task automatic start_and_wait(output int n);
        log_q.delete();
        sync = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            sync = 1'b0;
            n++;
        end while (!done && n < 3000);
        if (!done) n = -1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({av_read, av_write, av_address, av_writedata, armed, busy, done, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wd=%h armed=%b busy=%b done=%b to=%b, required all 0",
                     av_read, av_write, av_address, av_writedata, armed, busy, done, timeout_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (log_q.size() != 0 || armed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: txns=%0d armed=%b busy=%b, required 0 0 0",
                     log_q.size(), armed, busy);
        end
    endtask

    task automatic test_basic();
        int n, d;
        mem[0] = 16'h0005; slave_stopped = 1'b1;
        stage(0, 5'd0, 16'h1234);
        stage(1, 5'd2, 16'hBEEF);
        commit(2);
        checks++;
        if (armed !== 1'b1) begin
            errors++; $display("FAIL basic_armed: got %b, required 1", armed);
        end
        build_expected(16'h0005, 1'b1);
        start_and_wait(n);
        checks++;
        if (n != expected_latency()) begin
            errors++; $display("FAIL basic_latency: got %0d, required %0d", n, expected_latency());
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_txns: diff at %0d, got %0d txns, required %0d", d,
                     log_q.size(), exp_q.size());
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: done=%b busy=%b armed=%b, required 0 0 0", done, busy, armed);
        end
`ifdef CTS_READBACK_VERIFY_EN
        checks++;
        if (readback_err !== 1'b0) begin
            errors++; $display("FAIL basic_readback_err: got %b, required 0", readback_err);
        end
`endif
    endtask

    task automatic test_count_zero();
        int n, d;
        int hi_writes = 0;
        mem[0] = 16'h00A7; slave_stopped = 1'b1;
        commit(0);
        build_expected(16'h00A7, 1'b1);
        start_and_wait(n);
        checks++;
        if (n != 7) begin
            errors++; $display("FAIL zero_latency: got %0d, required 7", n);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL zero_txns: diff at %0d, got %0d txns, required %0d", d,
                               log_q.size(), exp_q.size());
        end
        foreach (log_q[i]) if (log_q[i][AW+DW] && log_q[i][AW+DW-1:DW] >= 5'd3) hi_writes++;
        checks++;
        if (hi_writes != 0) begin
            errors++; $display("FAIL zero_reg_writes: got %0d, required 0", hi_writes);
        end
    endtask

    task automatic test_sync_rules();
        int n, d;
        mem[0] = 16'h0013; slave_stopped = 1'b1;
        log_q.delete();
        sync = 1'b1; @(posedge clk); #1; sync = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (log_q.size() != 0 || armed !== 1'b0) begin
            errors++; $display("FAIL sync_idle: txns=%0d armed=%b, required 0 0", log_q.size(), armed);
        end
        stage(0, 5'd7, 16'h5A5A);
        stage(1, 5'd7, 16'hA5A5);
        cfg_commit = 1'b1; cfg_count = 3'd2; sync = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0; sync = 1'b0; m_count = 2;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (log_q.size() != 0 || armed !== 1'b1) begin
            errors++; $display("FAIL sync_with_commit: txns=%0d armed=%b, required 0 1",
                               log_q.size(), armed);
        end
        build_expected(16'h0013, 1'b1);
        sync = 1'b1; @(posedge clk); #1; sync = 1'b0;
        checks++;
        if (busy !== 1'b1 || armed !== 1'b0) begin
            errors++; $display("FAIL sync_busy: busy=%b armed=%b, required 1 0", busy, armed);
        end
        cfg_wr = 1'b1; cfg_index = 2'd0; cfg_reg = 5'h1C; cfg_data = 16'hDEAD;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL sync_done: got %b after %0d cycles, required 1", done, n);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL sync_txns: diff at %0d, got %0d txns, required %0d", d,
                               log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int n, d;
        mem[0] = 16'h000B; slave_stopped = 1'b0;
        stage(0, 5'd1, 16'h0101);
        stage(1, 5'd4, 16'h0404);
        commit(2);
        build_expected(16'h000B, 1'b0);
        start_and_wait(n);
        checks++;
        if (n < 0) begin
            errors++; $display("FAIL timeout_done: got no done, required done");
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL timeout_txns: diff at %0d, got %0d txns, required %0d", d,
                               log_q.size(), exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b, required 1", timeout_err);
        end
        commit(1);
        checks++;
        if (timeout_err !== 1'b0 || armed !== 1'b1) begin
            errors++; $display("FAIL timeout_clear: err=%b armed=%b, required 0 1", timeout_err, armed);
        end
        slave_stopped = 1'b1;
    endtask

    task automatic test_stalls();
        int n, d;
        logic [DW-1:0] ctrl;
        stall_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            ctrl = DW'($urandom_range(0, 65535)) | 16'h0001;
            mem[0] = ctrl;
            for (int i = 0; i < NE; i++)
                stage(i, AW'($urandom_range(0, 28)), DW'($urandom_range(0, 65535)));
            commit(int'($urandom_range(0, 7)));
            build_expected(ctrl, 1'b1);
            stab_err = 0;
            start_and_wait(n);
            d = first_diff();
            checks++;
            if (n < 0 || d != -1) begin
                errors++;
                $display("FAIL stall_txns[%0d]: lat=%0d diff at %0d, got %0d txns, required %0d",
                         it, n, d, log_q.size(), exp_q.size());
            end
            checks++;
            if (stab_err != 0) begin
                errors++; $display("FAIL stall_stable[%0d]: got %0d violations, required 0", it, stab_err);
            end
            @(posedge clk); #1;
        end
        stall_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mem[0] = 16'h0003; slave_stopped = 1'b1;
        stage(0, 5'd5, 16'h7777);
        stage(1, 5'd6, 16'h8888);
        commit(2);
        sync = 1'b1; @(posedge clk); #1; sync = 1'b0;
        while (!(av_write && av_address >= 5'd3) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!(av_write && av_address >= 5'd3)) begin
            errors++; $display("FAIL rstmid_reach: got no register write, required one");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({av_read, av_write, av_address, av_writedata, armed, busy, done, timeout_err} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: rd=%b wr=%b addr=%h wd=%h armed=%b busy=%b, required all 0",
                     av_read, av_write, av_address, av_writedata, armed, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        log_q.delete();
        sync = 1'b1; @(posedge clk); #1; sync = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (log_q.size() != 0 || armed !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: txns=%0d armed=%b busy=%b, required 0 0 0",
                               log_q.size(), armed, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < NE; i++) begin
            m_reg[i] = '0;
            m_data[i] = '0;
        end
        test_reset();
        test_basic();
        test_count_zero();
        test_sync_rules();
        test_timeout();
        test_stalls();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alt_vipcts131_ctrl_update_sequencer.md
Name: alt_vipcts131_ctrl_update_sequencer

Overview:
- Avalon-MM master that applies a staged batch of register writes to a downstream VIP control slave, and only at a safe point.
- The slave's map is fixed: addr 0 = control (bit0 go, bits[NO_INTERRUPTS:1] irq enables), addr 1 = status (bit0 stopped), addr 2 = irq, addr 3+i = register i.
- Update sequence: read control, clear go, poll stopped, write the staged registers, restore control with go set.
- Sits between the frame-sync/processor side and the core's slave port in the control-synchronizer path.

Parameters:
- AV_ADDRESS_WIDTH, 5, slave address width.
- AV_DATA_WIDTH, 16, slave data width.
- NO_ENTRIES, 4, staging buffer depth (max writes per batch); IDX_W = max(1, clog2(NO_ENTRIES)).
- POLL_LIMIT, 255, max status reads before timeout; range 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cfg_wr  in  1  write staging entry.
- cfg_index  in  IDX_W  entry index.
- cfg_reg  in  AV_ADDRESS_WIDTH  slave register index; master address = cfg_reg+3.
- cfg_data  in  AV_DATA_WIDTH  entry data.
- cfg_commit  in  1  arm the batch.
- cfg_count  in  IDX_W+1  number of valid entries, 0..NO_ENTRIES.
- sync  in  1  safe-point pulse (frame start).
- av_address  out  AV_ADDRESS_WIDTH  master address.
- av_read  out  1  read request.
- av_write  out  1  write request.
- av_writedata  out  AV_DATA_WIDTH  write data.
- av_readdata  in  AV_DATA_WIDTH  read data; valid exactly 1 cycle after the read is accepted.
- av_waitrequest  in  1  request not accepted this cycle.
- armed  out  1  batch pending.
- busy  out  1  sequence running.
- done  out  1  1-cycle pulse at sequence end.
- timeout_err  out  1  sticky; cleared by cfg_commit.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Entries and saved control word 0.
  - A reset mid-sequence abandons it immediately; no further bus activity.
- Bus rules:
  - av_read/av_write are held, with address and data stable, until a cycle with av_waitrequest=0.
  - At most one request per cycle; read and write never asserted together.
- Staging:
  - cfg_wr stores {cfg_reg, cfg_data} at cfg_index when the state is IDLE or ARMED; otherwise it is ignored.
  - cfg_index >= NO_ENTRIES is ignored.
- IDLE --cfg_commit--> ARMED:
  - Latches cfg_count, saturated to NO_ENTRIES.
  - Clears timeout_err.
  - cfg_commit in ARMED re-latches the count and stays ARMED.
  - cfg_commit while busy is ignored.
- ARMED --sync--> RD_CTRL:
  - sync is ignored in IDLE and while busy.
  - sync in the same cycle as the arming commit is not taken; earliest start is the next sync.
- States and transitions:
  - RD_CTRL: read addr 0; capture readdata 1 cycle after acceptance as ctrl_saved → WR_STOP.
  - WR_STOP: write addr 0 with ctrl_saved & ~1 (irq enables preserved) → POLL.
  - POLL: read addr 1, wait 1 cycle for data. If bit0=1 → WR_REG with k=0. Otherwise increment poll_cnt; when poll_cnt = POLL_LIMIT, set timeout_err → WR_GO, skipping all register writes.
  - WR_REG: write entry k (address cfg_reg+3, cfg_data); k++; when k = count → WR_GO. count=0 goes straight to WR_GO.
  - WR_GO: write addr 0 with ctrl_saved | 1 → IDLE. done pulses the cycle after acceptance. armed cleared.
- Status outputs:
  - busy=1 in all states except IDLE/ARMED.
  - armed=1 only in ARMED.
- Minimum latency, with waitrequest always 0 and stopped already 1:
  - sync to done = 2 (RD) + 1 (STOP) + 2 (POLL) + count + 1 (GO) + 1 cycles.
- Entries are written in ascending index order; duplicate addresses are allowed, and the last one wins.

Optional Feature:
- CTS_READBACK_VERIFY_EN defined:
  - After each WR_REG write, read the same address and compare with cfg_data.
  - A mismatch sets a sticky output readback_err (cleared by cfg_commit); the sequence continues.
  - Adds 2 cycles per entry.
- CTS_READBACK_VERIFY_EN undefined: no readback, and no readback_err port.

Decomposition:
- Shared package alt_vipcts131_ctrl_pkg:
  - state enum.
  - Address constants CTRL_ADDR=0, STATUS_ADDR=1, IRQ_ADDR=2, REG_BASE=3.
  - GO_BIT=0, STOPPED_BIT=0.
- One natural sub-module, alt_vipcts131_avmm_master_port: holds request/waitrequest handling and the 1-cycle read-data capture, exposing a req/ack/rdata_valid interface to the FSM.

Test Plan:
- Write entries (reg0=0x1234, reg2=0xBEEF), commit count=2, sync; slave control=0x0005, stopped=1 → bus sequence RD0, WR0=0x0004, RD1, WR3=0x1234, WR5=0xBEEF, WR0=0x0005; done 1 pulse; busy low after.
- Stopped held 0 with POLL_LIMIT=4 → exactly 4 reads of addr 1, timeout_err=1, no register writes, WR0 restores go; next commit clears timeout_err.
- Random av_waitrequest stalls → identical transaction list; address and data stable during each stall.
- Commit count=0, sync → RD0, WR0 (go cleared), poll, WR0 (go set); no addr≥3 writes.
- sync in IDLE and sync in the same cycle as commit → no bus activity; next sync starts the sequence. cfg_wr while busy does not alter the data written.
- rst low during WR_REG → all outputs 0 asynchronously, state IDLE; after release, sync causes no activity until a new commit.
